// File: rtl/render_scheduler.sv
// rtl/render_scheduler.sv - frame-paced draw/hold/erase sequencer for a sprite stage
module render_scheduler #(
    parameter int FRAME_DIV    = 833334,
    parameter int HOLD_FRAMES  = 4,
    parameter int ERASE_CYCLES = 44,
    parameter int DRAW_TIMEOUT = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic finish,
    output logic draw_signal,
    output logic erase_signal,
    output logic plot_en,
    output logic frame_tick,
    output logic busy,
    output logic err
);

    localparam int FW      = $clog2(FRAME_DIV + 1);
    localparam int CYC_MAX = (DRAW_TIMEOUT > ERASE_CYCLES) ? DRAW_TIMEOUT : ERASE_CYCLES;
    localparam int CW      = $clog2(CYC_MAX + 1);
    localparam int HW      = (HOLD_FRAMES > 0) ? $clog2(HOLD_FRAMES + 1) : 1;

    localparam logic [FW-1:0] FRAME_LAST = FW'(FRAME_DIV - 1);
    localparam logic [CW-1:0] DRAW_LIM   = CW'(DRAW_TIMEOUT);
    localparam logic [CW-1:0] ERASE_LIM  = CW'(ERASE_CYCLES);
    localparam logic [HW-1:0] HOLD_LIM   = HW'(HOLD_FRAMES);

    typedef enum logic [1:0] {IDLE, DRAW, HOLD, ERASE} state_t;

    state_t          state_q, state_d;
    logic [FW-1:0]   frame_cnt_q, frame_cnt_d;
    logic [CW-1:0]   cyc_q, cyc_d, cyc_inc;
    logic [HW-1:0]   hold_q, hold_d, hold_inc;
    logic            frame_tick_q, frame_tick_d;
    logic            draw_q, draw_d;
    logic            erase_q, erase_d;
    logic            plot_q, plot_d;
    logic            busy_q, busy_d;
    logic            err_q, err_d;

    always_comb begin
        frame_cnt_d  = (frame_cnt_q == FRAME_LAST) ? '0 : frame_cnt_q + 1'b1;
        frame_tick_d = (frame_cnt_d == FRAME_LAST);

        // Counters saturate rather than wrap.
        cyc_inc  = (cyc_q == '1) ? cyc_q : cyc_q + 1'b1;
        hold_inc = (hold_q == '1) ? hold_q : hold_q + 1'b1;

        state_d = state_q;
        cyc_d   = cyc_inc;
        hold_d  = hold_q;
        err_d   = err_q;

        case (state_q)
            IDLE: begin
                cyc_d = '0;
                if (enable && frame_tick_q) state_d = DRAW;
            end
            DRAW: begin
                if (finish) begin
                    state_d = HOLD;
                end else if (cyc_inc == DRAW_LIM) begin
                    err_d   = 1'b1;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                cyc_d = '0;
                if (HOLD_FRAMES == 0) begin
                    state_d = ERASE;
                end else if (frame_tick_q) begin
                    hold_d = hold_inc;
                    if (hold_inc == HOLD_LIM) state_d = ERASE;
                end
            end
            ERASE: begin
                if (cyc_inc == ERASE_LIM) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (state_d != state_q) begin
            cyc_d  = '0;
            hold_d = '0;
        end

        // Outputs follow the next state so they line up with state_q.
        draw_d  = (state_d == DRAW);
        erase_d = (state_d == ERASE);
        plot_d  = (state_d == DRAW) || (state_d == ERASE);
        busy_d  = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            frame_cnt_q  <= '0;
            cyc_q        <= '0;
            hold_q       <= '0;
            frame_tick_q <= 1'b0;
            draw_q       <= 1'b0;
            erase_q      <= 1'b0;
            plot_q       <= 1'b0;
            busy_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            frame_cnt_q  <= frame_cnt_d;
            cyc_q        <= cyc_d;
            hold_q       <= hold_d;
            frame_tick_q <= frame_tick_d;
            draw_q       <= draw_d;
            erase_q      <= erase_d;
            plot_q       <= plot_d;
            busy_q       <= busy_d;
            err_q        <= err_d;
        end
    end

    assign draw_signal  = draw_q;
    assign erase_signal = erase_q;
    assign plot_en      = plot_q;
    assign frame_tick   = frame_tick_q;
    assign busy         = busy_q;
    assign err          = err_q;

endmodule

// File: tb/tb_render_scheduler.sv
// tb/tb_render_scheduler.sv - directed self-checking bench for render_scheduler
module tb_render_scheduler;

    logic clk = 1'b0;
    logic reset, enable, finish;
    logic draw_signal, erase_signal, plot_en, frame_tick, busy, err;

    int n_cmp = 0;
    int n_bad = 0;
    logic overlap_seen = 1'b0;
    logic busy_seen;
    int   n, ticks;

    render_scheduler #(
        .FRAME_DIV(10), .HOLD_FRAMES(2), .ERASE_CYCLES(44), .DRAW_TIMEOUT(64)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .finish(finish),
        .draw_signal(draw_signal), .erase_signal(erase_signal), .plot_en(plot_en),
        .frame_tick(frame_tick), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (draw_signal && erase_signal) overlap_seen = 1'b1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic sel(input int w);
        return (w == 0) ? draw_signal : erase_signal;
    endfunction

    task automatic wait_for(input int w, input int bound, output int cnt);
        cnt = 0;
        while (!sel(w) && cnt < bound) begin
            step();
            cnt++;
        end
    endtask

    task automatic measure_high(input int w, input int bound, output int cnt);
        cnt = 0;
        while (sel(w) && cnt < bound) begin
            step();
            cnt++;
        end
    endtask

    initial begin
        reset = 1'b1; enable = 1'b1; finish = 1'b0;
        repeat (3) step();
        check("rst_outputs", {26'd0, draw_signal, erase_signal, plot_en, frame_tick, busy, err}, 32'd0);

        // Cycle 1 after release has count 0; tick lands in cycle 10.
        reset = 1'b0;
        repeat (8) step();
        check("no_early_tick", frame_tick, 1'b0);
        step();
        check("first_tick", frame_tick, 1'b1);
        check("idle_busy", busy, 1'b0);
        step();
        check("draw_start", {draw_signal, plot_en, busy}, 3'b111);

        // Finish in the 42nd DRAW cycle.
        repeat (41) step();
        check("draw_before_finish", draw_signal, 1'b1);
        finish = 1'b1;
        step();
        finish = 1'b0;
        check("draw_drop", {draw_signal, plot_en, busy}, 3'b001);
        wait_for(1, 40, n);
        check("hold_to_erase", n, 18);
        check("erase_plot", plot_en, 1'b1);
        measure_high(1, 100, n);
        check("erase_len", n, 44);
        check("idle_after_erase", busy, 1'b0);
        check("no_err_yet", err, 1'b0);

        // Timeout: finish never arrives.
        wait_for(0, 30, n);
        check("redraw_wait", n, 6);
        measure_high(0, 100, n);
        check("timeout_len", n, 64);
        check("timeout_err", err, 1'b1);

        // Drop enable in HOLD; finish held high through HOLD/ERASE is ignored.
        enable = 1'b0;
        finish = 1'b1;
        wait_for(1, 40, n);
        check("hold_to_erase2", n, 16);
        measure_high(1, 100, n);
        check("erase_len2", n, 44);
        finish = 1'b0;
        check("idle_after_seq2", busy, 1'b0);
        busy_seen = 1'b0;
        ticks = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (busy) busy_seen = 1'b1;
            if (frame_tick) ticks++;
        end
        check("stay_idle", busy_seen, 1'b0);
        check("idle_ticks", ticks, 3);
        check("err_sticky", err, 1'b1);

        // Finish coincides with a frame tick in DRAW.
        enable = 1'b1;
        wait_for(0, 30, n);
        check("redraw_wait2", n, 6);
        repeat (9) step();
        check("tick_in_draw", {frame_tick, draw_signal}, 2'b11);
        finish = 1'b1;
        step();
        finish = 1'b0;
        check("draw_drop2", draw_signal, 1'b0);
        wait_for(1, 40, n);
        check("tick_not_counted", n, 20);
        check("err_sticky2", err, 1'b1);

        // Reset during the 20th ERASE cycle.
        repeat (19) step();
        check("erase_20th", erase_signal, 1'b1);
        reset = 1'b1;
        step();
        check("rst_mid_erase", {erase_signal, plot_en, busy, err}, 4'b0000);
        reset = 1'b0;
        enable = 1'b0;
        finish = 1'b1;
        repeat (8) step();
        check("no_early_tick2", frame_tick, 1'b0);
        step();
        check("tick_after_rst", frame_tick, 1'b1);
        check("finish_idle_no_err", {busy, err}, 2'b00);
        finish = 1'b0;

        check("no_overlap", overlap_seen, 1'b0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
